// File: rtl/ch_scan_ctrl.sv
// ch_scan_ctrl: per-sample channel scanner feeding muxed words to an RX FIFO as frames
module ch_scan_ctrl #(
  parameter int DW     = 16,
  parameter int MAX_CH = 8,
  parameter int SELW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            strobe,
  input  logic [3:0]      numch,
  input  logic [DW-1:0]   mux_data,
  output logic [SELW-1:0] sel,
  input  logic            fifo_full,
  output logic            wr_en,
  output logic [DW-1:0]   wr_data,
  output logic            wr_sof,
  output logic            busy,
  input  logic            ovr_clr,
  output logic            overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic [3:0]      r_nlat, w_nlat_nxt, w_nclamp;
  logic            w_start, w_write, w_last;
  logic            r_wr_en, r_wr_sof, r_busy, r_ovr;
  logic [DW-1:0]   r_wr_data;
  // next-state: start/continue/finish a frame, with back-to-back restart on the last word
  always_comb begin
    w_nclamp    = (numch > 4'(MAX_CH)) ? 4'(MAX_CH) : numch;
    w_start     = strobe && (numch != 4'd0);
    w_write     = (r_state == SCAN) && !fifo_full;
    w_last      = w_write && (4'(r_sel) == r_nlat - 4'd1);
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_nlat_nxt  = r_nlat;
    if (r_state == IDLE) begin
      if (w_start) begin
        w_state_nxt = SCAN;
        w_sel_nxt   = '0;
        w_nlat_nxt  = w_nclamp;
      end
    end else if (w_last) begin
      w_sel_nxt   = '0;
      w_state_nxt = w_start ? SCAN : IDLE;
      w_nlat_nxt  = w_start ? w_nclamp : r_nlat;
    end else if (w_write) begin
      w_sel_nxt = r_sel + 1'b1;
    end
  end
  // state, write pulses and sticky overrun (set wins over clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_nlat    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_wr_sof  <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_nlat    <= w_nlat_nxt;
      r_wr_en   <= w_write;
      r_wr_data <= w_write ? mux_data : r_wr_data;
      r_wr_sof  <= w_write && (r_sel == '0);
      r_busy    <= (w_state_nxt == SCAN);
      r_ovr     <= (strobe && r_state == SCAN && !w_last) ? 1'b1 : ovr_clr ? 1'b0 : r_ovr;
    end
  end
  assign sel     = r_sel;
  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign wr_sof  = r_wr_sof;
  assign busy    = r_busy;
  assign overrun = r_ovr;
endmodule
